preg_free_list: RTL and testbench

Physical-register free-list manager for the rename stage. It hands out up to two free physical-register tags per cycle to the two decode slots, which take the destinations of the instruction pair fetched together. It accepts up to two released tags per cycle from commit. Storage is a circular FIFO of tags with all-or-nothing grant arbitration, occupancy tracking and sticky error reporting.

---
 rtl/preg_free_list_if.sv | 27 ++
 rtl/preg_free_list.sv | 115 +++++++++++
 tb/tb_preg_free_list.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/preg_free_list_if.sv
// Rename-stage free-list bus: decode allocation requests/grants, commit releases and status.
interface preg_free_list_if #(
  parameter int TAG_W = 6,
  parameter int CNT_W = 6
);
  logic [1:0]       alloc_req;
  logic [1:0]       alloc_gnt;
  logic [TAG_W-1:0] alloc_tag0;
  logic [TAG_W-1:0] alloc_tag1;
  logic [1:0]       free_vld;
  logic [TAG_W-1:0] free_tag0;
  logic [TAG_W-1:0] free_tag1;
  logic [CNT_W-1:0] free_count;
  logic             empty;
  logic             err_ovf;
  logic             err_dup;

  modport master (
    output alloc_req, free_vld, free_tag0, free_tag1,
    input  alloc_gnt, alloc_tag0, alloc_tag1, free_count, empty, err_ovf, err_dup
  );

  modport slave (
    input  alloc_req, free_vld, free_tag0, free_tag1,
    output alloc_gnt, alloc_tag0, alloc_tag1, free_count, empty, err_ovf, err_dup
  );
endinterface

// File: rtl/preg_free_list.sv
// Physical-register free list: circular FIFO of tags, 2-wide all-or-nothing allocate, 2-wide release.
// Define PREG_FREELIST_CHECK_EN to add the in_list bitmap that drops duplicate releases (err_dup).
module preg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int TAG_W     = $clog2(NUM_PREGS)
) (
  input logic             clk,
  input logic             rst_n,
  preg_free_list_if.slave bus
);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] entry_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W-1:0] head_d, tail_d;
  logic [PTR_W-1:0] headPlus1, wrIdx1;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_ovf_q;

  logic [1:0] reqCnt, popCnt, gnt;
  logic       dup0, dup1, acc0, acc1, ovfHit;

  // Grants are judged against the pre-release count; reset forces them off.
  always_comb begin
    reqCnt = {1'b0, bus.alloc_req[0]} + {1'b0, bus.alloc_req[1]};
    gnt    = 2'b00;
    if (rst_n && (count_q >= CNT_W'(reqCnt))) begin
      gnt = bus.alloc_req;
    end
    popCnt = {1'b0, gnt[0]} + {1'b0, gnt[1]};
  end

  assign headPlus1      = head_q + PTR_W'(1);
  assign bus.alloc_gnt  = gnt;
  assign bus.alloc_tag0 = entry_q[head_q];
  assign bus.alloc_tag1 = (bus.alloc_req == 2'b10) ? entry_q[head_q] : entry_q[headPlus1];

`ifdef PREG_FREELIST_CHECK_EN
  logic [NUM_PREGS-1:0] in_list_q;
  logic                 err_dup_q;
`endif

  // Duplicate screening first, then space; free1 sees the slot free0 just took.
  always_comb begin
    dup0 = 1'b0;
    dup1 = 1'b0;
`ifdef PREG_FREELIST_CHECK_EN
    dup0 = in_list_q[bus.free_tag0];
    dup1 = in_list_q[bus.free_tag1] || (bus.free_vld[0] && (bus.free_tag0 == bus.free_tag1));
`endif
    acc0   = bus.free_vld[0] && !dup0 && (count_q != CNT_W'(DEPTH));
    acc1   = bus.free_vld[1] && !dup1 && ((count_q + CNT_W'(acc0)) != CNT_W'(DEPTH));
    ovfHit = (bus.free_vld[0] && !dup0 && !acc0) || (bus.free_vld[1] && !dup1 && !acc1);
    wrIdx1 = acc0 ? (tail_q + PTR_W'(1)) : tail_q;
    head_d  = head_q + PTR_W'(popCnt);
    tail_d  = tail_q + PTR_W'(acc0) + PTR_W'(acc1);
    count_d = count_q - CNT_W'(popCnt) + CNT_W'(acc0) + CNT_W'(acc1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= CNT_W'(DEPTH);
      err_ovf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= TAG_W'(NUM_AREGS + i);
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (acc0) begin
        entry_q[tail_q] <= bus.free_tag0;
      end
      if (acc1) begin
        entry_q[wrIdx1] <= bus.free_tag1;
      end
      if (ovfHit) begin
        err_ovf_q <= 1'b1;
      end
    end
  end

  assign bus.free_count = count_q;
  assign bus.empty      = (count_q == '0);
  assign bus.err_ovf    = err_ovf_q;

`ifdef PREG_FREELIST_CHECK_EN
  // Bitmap mirrors list membership: grants clear, accepted releases set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_dup_q <= 1'b0;
      for (int i = 0; i < NUM_PREGS; i++) begin
        in_list_q[i] <= (i >= NUM_AREGS);
      end
    end else begin
      if (gnt[0]) in_list_q[bus.alloc_tag0] <= 1'b0;
      if (gnt[1]) in_list_q[bus.alloc_tag1] <= 1'b0;
      if (acc0)   in_list_q[bus.free_tag0]  <= 1'b1;
      if (acc1)   in_list_q[bus.free_tag1]  <= 1'b1;
      if ((bus.free_vld[0] && dup0) || (bus.free_vld[1] && dup1)) begin
        err_dup_q <= 1'b1;
      end
    end
  end

  assign bus.err_dup = err_dup_q;
`else
  assign bus.err_dup = 1'b0;
`endif
endmodule

// File: tb/tb_preg_free_list.sv
// Self-checking bench for preg_free_list: queue-based free-list model plus directed and random stimulus.
module tb_preg_free_list;
  localparam int DEPTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  preg_free_list_if bus ();
  preg_free_list dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  int fl[$];
  bit inList[64];
  bit mErrOvf, mErrDup;
  bit checkEn = 1'b0;

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    fl.delete();
    for (int i = 0; i < DEPTH; i++) fl.push_back(32 + i);
    for (int i = 0; i < 64; i++) inList[i] = (i >= 32);
    mErrOvf = 1'b0;
    mErrDup = 1'b0;
  endtask

  function automatic logic [1:0] expGrant(input logic [1:0] req);
    int n;
    n = int'(req[0]) + int'(req[1]);
    return (fl.size() >= n) ? req : 2'b00;
  endfunction

  task automatic checkOutput();
    logic [1:0] g;
    g = expGrant(bus.alloc_req);
    checkVal("alloc_gnt", bus.alloc_gnt, g);
    if (g[0]) checkVal("alloc_tag0", bus.alloc_tag0, fl[0]);
    if (g == 2'b11) checkVal("alloc_tag1", bus.alloc_tag1, fl[1]);
    else if (g == 2'b10) checkVal("alloc_tag1", bus.alloc_tag1, fl[0]);
    checkVal("free_count", bus.free_count, fl.size());
    checkVal("empty", bus.empty, fl.size() == 0);
    checkVal("err_ovf", bus.err_ovf, mErrOvf);
    checkVal("err_dup", bus.err_dup, mErrDup);
  endtask

  // Advance the model by one clock: pops first, then releases judged against the pre-pop size.
  task automatic modelStep();
    logic [1:0] g;
    int base, accepted, t;
    bit dup;
    g = expGrant(bus.alloc_req);
    base = fl.size();
    accepted = 0;
    for (int i = 0; i < 2; i++) begin
      if (g[i]) begin
        t = fl.pop_front();
        inList[t] = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (bus.free_vld[i]) begin
        t = (i == 0) ? int'(bus.free_tag0) : int'(bus.free_tag1);
        dup = 1'b0;
`ifdef PREG_FREELIST_CHECK_EN
        dup = inList[t] || (i == 1 && bus.free_vld[0] && bus.free_tag0 == bus.free_tag1);
`endif
        if (dup) mErrDup = 1'b1;
        else if (base + accepted >= DEPTH) mErrOvf = 1'b1;
        else begin
          fl.push_back(t);
          inList[t] = 1'b1;
          accepted++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && checkEn) begin
      checkOutput();
      modelStep();
    end
  end

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] vld,
                               input logic [5:0] t0, input logic [5:0] t1);
    @(posedge clk);
    #1;
    bus.alloc_req = req;
    bus.free_vld  = vld;
    bus.free_tag0 = t0;
    bus.free_tag1 = t1;
  endtask

  task automatic doReset();
    #1;
    rst_n = 1'b0;
    bus.alloc_req = 2'b00;
    bus.free_vld  = 2'b00;
    bus.free_tag0 = '0;
    bus.free_tag1 = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.alloc_req = 2'b00;
    bus.free_vld  = 2'b00;
    bus.free_tag0 = '0;
    bus.free_tag1 = '0;
    doReset();
    checkEn = 1'b1;

    // First pair allocation, then drain to empty and reuse a released tag
    applyStimulus(2'b11, 2'b00, 0, 0);
    #2;
    checkVal("first_gnt", bus.alloc_gnt, 2'b11);
    checkVal("first_tag0", bus.alloc_tag0, 32);
    checkVal("first_tag1", bus.alloc_tag1, 33);
    applyStimulus(2'b11, 2'b00, 0, 0);
    #2;
    checkVal("count_after_pair", bus.free_count, 30);
    repeat (14) applyStimulus(2'b11, 2'b00, 0, 0);
    applyStimulus(2'b01, 2'b01, 5, 0);
    #2;
    checkVal("drained_count", bus.free_count, 0);
    checkVal("drained_empty", bus.empty, 1);
    checkVal("empty_stall_gnt", bus.alloc_gnt, 2'b00);
    applyStimulus(2'b01, 2'b00, 0, 0);
    #2;
    checkVal("reuse_count", bus.free_count, 1);
    checkVal("reuse_gnt", bus.alloc_gnt, 2'b01);
    checkVal("reuse_tag0", bus.alloc_tag0, 5);

    // One entry left: a pair stalls entirely, a lone slot-1 request gets it
    applyStimulus(2'b00, 2'b01, 6, 0);
    applyStimulus(2'b11, 2'b00, 0, 0);
    #2;
    checkVal("one_left_count", bus.free_count, 1);
    checkVal("pair_stall_gnt", bus.alloc_gnt, 2'b00);
    applyStimulus(2'b10, 2'b00, 0, 0);
    #2;
    checkVal("slot1_gnt", bus.alloc_gnt, 2'b10);
    checkVal("slot1_tag1", bus.alloc_tag1, 6);
    applyStimulus(2'b00, 2'b00, 0, 0);
    #2;
    checkVal("slot1_count", bus.free_count, 0);

    // Walk head and tail to 31, then straddle the wrap with a pair pop and pair push
    doReset();
    for (int i = 0; i < 31; i++) begin
      applyStimulus(2'b01, 2'b00, 0, 0);
      applyStimulus(2'b00, 2'b01, 6'(i), 0);
    end
    applyStimulus(2'b11, 2'b00, 0, 0);
    #2;
    checkVal("wrap_pop_tag0", bus.alloc_tag0, 63);
    checkVal("wrap_pop_tag1", bus.alloc_tag1, 0);
    applyStimulus(2'b00, 2'b11, 50, 51);
    #2;
    checkVal("wrap_mid_count", bus.free_count, 30);
    applyStimulus(2'b00, 2'b00, 0, 0);
    #2;
    checkVal("wrap_full_count", bus.free_count, 32);
    repeat (15) applyStimulus(2'b11, 2'b00, 0, 0);
    applyStimulus(2'b11, 2'b00, 0, 0);
    #2;
    checkVal("wrap_push_tag0", bus.alloc_tag0, 50);
    checkVal("wrap_push_tag1", bus.alloc_tag1, 51);

    // Releases into a full list
    doReset();
    applyStimulus(2'b00, 2'b11, 40, 41);
    applyStimulus(2'b00, 2'b00, 0, 0);
    #2;
    checkVal("full_rel_count", bus.free_count, 32);
`ifdef PREG_FREELIST_CHECK_EN
    checkVal("full_rel_dup", bus.err_dup, 1);
    checkVal("full_rel_ovf", bus.err_ovf, 0);
    doReset();
    applyStimulus(2'b01, 2'b00, 0, 0);
    applyStimulus(2'b00, 2'b11, 32, 32);
    applyStimulus(2'b00, 2'b00, 0, 0);
    #2;
    checkVal("dup_pair_count", bus.free_count, 32);
    checkVal("dup_pair_err", bus.err_dup, 1);
`else
    checkVal("full_rel_ovf", bus.err_ovf, 1);
    checkVal("full_rel_dup", bus.err_dup, 0);
`endif

    // Asynchronous reset in the middle of a pair burst
    doReset();
    repeat (3) applyStimulus(2'b11, 2'b00, 0, 0);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkVal("midrst_count", bus.free_count, 32);
    checkVal("midrst_gnt", bus.alloc_gnt, 2'b00);
    checkVal("midrst_ovf", bus.err_ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkVal("postrst_tag0", bus.alloc_tag0, 32);

    // Random traffic alternating allocate-heavy and release-heavy phases
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] req, vld;
      if (i == 1500) doReset();
      if (((i / 200) % 2) == 0) begin
        req = 2'($urandom);
        vld = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      end else begin
        req = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        vld = 2'($urandom);
      end
      applyStimulus(req, vld, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    end
    applyStimulus(2'b00, 2'b00, 0, 0);
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
